risk_strided_mem: RTL

- Parametrised banked scratchpad that gathers (load) or scatters (store) a full SZ x SZ_Y tile of BITS-wide elements in one request.
- Element addresses are base + stride_x*x + stride_y*y.
- Addresses are interleaved across 2^LOGCNT single-port banks.
- Bank conflicts are serialised into rounds rather than dropped, so any stride pair is legal.
- Sits between the risk register file and the bank array, behind a valid/ready request/response handshake.

---
 rtl/risk_strided_mem_if.sv | 33 +++
 rtl/risk_strided_mem.sv | 133 +++++++++++++
 2 files changed

// File: rtl/risk_strided_mem_if.sv
// risk_strided_mem_if: request/response handshake bundle for the strided tile scratchpad
interface risk_strided_mem_if #(
    parameter int BITS      = 18,
    parameter int SZ        = 4,
    parameter int SZ_Y      = 4,
    parameter int LOGCNT    = 4,
    parameter int DEPTH_LOG = 10,
    parameter int ADDR_W    = LOGCNT + DEPTH_LOG,
    parameter int N         = SZ * SZ_Y,
    parameter int ROUND_W   = $clog2(N + 1)
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_stride_x;
    logic [ADDR_W-1:0] req_stride_y;
    logic [N*BITS-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [N*BITS-1:0] resp_data;
    logic [ROUND_W-1:0] resp_rounds;

    modport master (
        output req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rounds
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rounds
    );
endinterface

// File: rtl/risk_strided_mem.sv
// risk_strided_mem: banked scratchpad gathering/scattering a strided SZ x SZ_Y tile, bank conflicts serialised into rounds
module risk_strided_mem #(
    parameter int BITS      = 18,
    parameter int SZ        = 4,
    parameter int SZ_Y      = 4,
    parameter int LOGCNT    = 4,
    parameter int DEPTH_LOG = 10,
    parameter int ADDR_W    = LOGCNT + DEPTH_LOG,
    parameter int N         = SZ * SZ_Y,
    parameter int ROUND_W   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    risk_strided_mem_if.slave bus,
    output logic             busy
);
    localparam int BANKS = 1 << LOGCNT;
    localparam int ROWS  = 1 << DEPTH_LOG;
    localparam int EW    = $clog2(N);

    typedef enum logic [2:0] {IDLE, ADDR, ISSUE, DRAIN, RESP} state_t;

    state_t             state, state_nx;
    logic               we_q;
    logic [ADDR_W-1:0]  base_q, sx_q, sy_q;
    logic [N*BITS-1:0]  data_q, result_q;
    logic [ADDR_W-1:0]  addr_q [N];
    logic [N-1:0]       pending, grant;
    logic [ROUND_W-1:0] round_q;
    logic [BANKS-1:0]   bank_en, rd_vld;
    logic [EW-1:0]      bank_sel [BANKS];
    logic [EW-1:0]      rd_lane [BANKS];
    logic [BITS-1:0]    rd_q [BANKS];
    logic [BITS-1:0]    mem [BANKS][ROWS];

    // state register; reset drops any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state: one address cycle, one cycle per round, one drain cycle, then hold the response
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req_valid ? ADDR : IDLE;
            ADDR:    state_nx = ISSUE;
            ISSUE:   state_nx = ((pending & ~grant) == '0) ? DRAIN : ISSUE;
            DRAIN:   state_nx = RESP;
            RESP:    state_nx = bus.resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.req_ready   = (state == IDLE);
        bus.resp_valid  = (state == RESP);
        busy            = (state != IDLE);
        bus.resp_data   = result_q;
        bus.resp_rounds = round_q;
    end

    // an element wins its bank this round only if no lower-index pending element maps to the same bank
    always_comb begin
        grant = pending;
        for (int e = 0; e < N; e++)
            for (int j = 0; j < N; j++)
                if (j < e && pending[j] && addr_q[j][LOGCNT-1:0] == addr_q[e][LOGCNT-1:0])
                    grant[e] = 1'b0;
    end

    // route each granted element to its bank port
    always_comb begin
        bank_en = '0;
        for (int b = 0; b < BANKS; b++) bank_sel[b] = '0;
        for (int e = 0; e < N; e++)
            if (state == ISSUE && grant[e]) begin
                bank_en[addr_q[e][LOGCNT-1:0]]  = 1'b1;
                bank_sel[addr_q[e][LOGCNT-1:0]] = EW'(e);
            end
    end

    // single-port banks: each enabled bank either writes or reads its selected row
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++)
            if (bank_en[b]) begin
                if (we_q) mem[b][addr_q[bank_sel[b]][ADDR_W-1:LOGCNT]] <= data_q[bank_sel[b]*BITS +: BITS];
                else      rd_q[b] <= mem[b][addr_q[bank_sel[b]][ADDR_W-1:LOGCNT]];
            end
    end

    // request latch, address generation, round bookkeeping and load-lane capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            base_q   <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            data_q   <= '0;
            result_q <= '0;
            pending  <= '0;
            round_q  <= '0;
            rd_vld   <= '0;
            for (int e = 0; e < N; e++) addr_q[e] <= '0;
            for (int b = 0; b < BANKS; b++) rd_lane[b] <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we_q     <= bus.req_we;
                base_q   <= bus.req_addr;
                sx_q     <= bus.req_stride_x;
                sy_q     <= bus.req_stride_y;
                data_q   <= bus.req_data;
                result_q <= '0;
            end
            if (state == ADDR) begin
                for (int e = 0; e < N; e++)
                    addr_q[e] <= base_q + sx_q * ADDR_W'(e % SZ) + sy_q * ADDR_W'(e / SZ);
                pending <= '1;
                round_q <= '0;
            end
            if (state == ISSUE) begin
                pending <= pending & ~grant;
                round_q <= round_q + 1'b1;
            end
            rd_vld <= (state == ISSUE && !we_q) ? bank_en : '0;
            for (int b = 0; b < BANKS; b++) begin
                rd_lane[b] <= bank_sel[b];
                if (rd_vld[b]) result_q[rd_lane[b]*BITS +: BITS] <= rd_q[b];
            end
        end
    end
endmodule
